ether_cmd_sched: RTL and testbench

Command-frame scheduler for the Ethernet PHY management serial link. Several requesters share a single serial frame engine: a front-panel button sequencer, a host register bridge and a power-cycle timer. The block arbitrates between them round-robin and latches the granted requester's frame. It then shifts the frame out MSB-first on a divided bit clock and enforces a fixed idle gap before the next frame.

---
 rtl/ether_cmd_pkg.sv | 18 +
 rtl/ether_frame_shifter.sv | 76 +++++++
 rtl/ether_cmd_sched.sv | 169 ++++++++++++++++
 tb/tb_ether_cmd_sched.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ether_cmd_pkg.sv
// Shared types and constants for the PHY management command-frame scheduler.
// Holds the scheduler state encoding, default geometry and the standard command frames.
package ether_cmd_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      GAP   = 2'd2
   } state_t;

   localparam int DEF_FRAME_LEN = 58;
   localparam int DEF_CLK_DIV   = 160;

   localparam logic [57:0] CMD_SEND_OUT = 58'h2F0_0000_0000_00FF;
   localparam logic [57:0] CMD_PHY_OFF  = 58'h3C4_A5F0_1234_5678;
   localparam logic [57:0] CMD_PHY_ON   = 58'h1D2_5A0F_8765_4321;

endpackage

// File: rtl/ether_frame_shifter.sv
// Serialises one frame MSB-first on a divided bit clock; each bit lasts 2*CLK_DIV cycles, clock low half first.
// Starts on the edge that samples load_in; done_out flags the final cycle of the last bit (no backpressure).
module ether_frame_shifter #(
   parameter int   FRAME_LEN  = 58,
   parameter int   CLK_DIV    = 160,
   parameter logic IDLE_LEVEL = 1'b1
) (
   input  logic                 clk_in,
   input  logic                 reset_in,
   input  logic                 load_in,
   input  logic [FRAME_LEN-1:0] frame_in,
   output logic                 done_out,
   output logic                 ser_clk_out,
   output logic                 ser_data_out
);

   localparam int DW = $clog2(2 * CLK_DIV);
   localparam int BW = $clog2(FRAME_LEN + 1);

   localparam logic [DW-1:0] DIV_LAST = DW'(2 * CLK_DIV - 1);
   localparam logic [DW-1:0] DIV_HALF = DW'(CLK_DIV);
   localparam logic [BW-1:0] BIT_LAST = BW'(FRAME_LEN - 1);

   logic                 active_q, active_d;
   logic [DW-1:0]        div_q, div_d;
   logic [BW-1:0]        bit_q, bit_d;
   logic [FRAME_LEN-1:0] sh_q, sh_d;
   logic                 bit_end;

   always_comb begin
      active_d = active_q;
      div_d    = div_q;
      bit_d    = bit_q;
      sh_d     = sh_q;
      done_out = 1'b0;
      bit_end  = active_q && (div_q == DIV_LAST);

      if (load_in) begin
         active_d = 1'b1;
         div_d    = '0;
         bit_d    = '0;
         sh_d     = frame_in;
      end else if (bit_end) begin
         div_d = '0;
         if (bit_q == BIT_LAST) begin
            active_d = 1'b0;
            bit_d    = '0;
            done_out = 1'b1;
         end else begin
            bit_d = bit_q + 1'b1;
            sh_d  = sh_q << 1;
         end
      end else if (active_q) begin
         div_d = div_q + 1'b1;
      end
   end

   always_ff @(posedge clk_in) begin
      if (!reset_in) begin
         active_q <= 1'b0;
         div_q    <= '0;
         bit_q    <= '0;
         sh_q     <= '0;
      end else begin
         active_q <= active_d;
         div_q    <= div_d;
         bit_q    <= bit_d;
         sh_q     <= sh_d;
      end
   end

   // Data changes only with the shift register, i.e. at bit start, so it is stable across the rising edge.
   assign ser_clk_out  = active_q ? (div_q >= DIV_HALF) : 1'b1;
   assign ser_data_out = active_q ? sh_q[FRAME_LEN-1] : IDLE_LEVEL;

endmodule

// File: rtl/ether_cmd_sched.sv
// Round-robin scheduler sharing one serial command-frame engine; grant one cycle after the sampling edge, then frame + idle gap.
// Requests are level-held and ignored while shifting or in the gap; ETHER_CMD_SCHED_STATS_EN adds a completed-frame counter.
module ether_cmd_sched
   import ether_cmd_pkg::*;
#(
   parameter int   NREQ       = 3,
   parameter int   FRAME_LEN  = DEF_FRAME_LEN,
   parameter int   CLK_DIV    = DEF_CLK_DIV,
   parameter int   GAP_BITS   = 16,
   parameter logic IDLE_LEVEL = 1'b1
) (
   input  logic                      clk_in,
   input  logic                      reset_in,
   input  logic [NREQ-1:0]           req_in,
   input  logic [NREQ*FRAME_LEN-1:0] frame_in,
   output logic [NREQ-1:0]           gnt_out,
   output logic [NREQ-1:0]           done_out,
   output logic                      busy_out,
   output logic                      ser_clk_out,
   output logic                      ser_data_out
`ifdef ETHER_CMD_SCHED_STATS_EN
   ,
   output logic [15:0]               frame_cnt_out
`endif
);

   localparam int PW      = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int GAP_CYC = GAP_BITS * 2 * CLK_DIV;
   localparam int GW      = $clog2(GAP_CYC + 1);

   // The done cycle is itself the first gap cycle, so the counter covers the remaining GAP_CYC-1.
   localparam logic [GW-1:0] GAP_LOAD = GW'(GAP_CYC - 1);

   state_t               state_q, state_d;
   logic [PW-1:0]        ptr_q, ptr_d;
   logic [NREQ-1:0]      gnt_q, gnt_d;
   logic [NREQ-1:0]      owner_q, owner_d;
   logic [NREQ-1:0]      done_q, done_d;
   logic [GW-1:0]        gap_q, gap_d;

   logic                 found;
   logic [PW-1:0]        pick;
   logic [NREQ-1:0]      pick_oh;
   logic [FRAME_LEN-1:0] frame_sel;
   logic                 load;
   logic                 shift_end;

   always_comb begin
      found   = 1'b0;
      pick    = ptr_q;
      pick_oh = '0;
      for (int off = 0; off < NREQ; off++) begin
         for (int i = 0; i < NREQ; i++) begin
            if (!found && req_in[i] && (((int'(ptr_q) + off) % NREQ) == i)) begin
               found      = 1'b1;
               pick       = PW'(i);
               pick_oh[i] = 1'b1;
            end
         end
      end
   end

   always_comb begin
      frame_sel = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (pick_oh[i]) begin
            frame_sel = frame_in[i*FRAME_LEN +: FRAME_LEN];
         end
      end
   end

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      gnt_d   = '0;
      owner_d = owner_q;
      done_d  = '0;
      gap_d   = gap_q;
      load    = 1'b0;

      case (state_q)
         IDLE: begin
            if (found) begin
               load    = 1'b1;
               gnt_d   = pick_oh;
               owner_d = pick_oh;
               ptr_d   = (int'(pick) == NREQ - 1) ? '0 : pick + 1'b1;
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            if (shift_end) begin
               done_d  = owner_q;
               gap_d   = GAP_LOAD;
               state_d = GAP;
            end
         end
         GAP: begin
            if (gap_q <= GW'(1)) begin
               gap_d   = '0;
               state_d = IDLE;
            end else begin
               gap_d = gap_q - 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_in) begin
      if (!reset_in) begin
         state_q <= IDLE;
         ptr_q   <= '0;
         gnt_q   <= '0;
         owner_q <= '0;
         done_q  <= '0;
         gap_q   <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         gnt_q   <= gnt_d;
         owner_q <= owner_d;
         done_q  <= done_d;
         gap_q   <= gap_d;
      end
   end

   ether_frame_shifter #(
      .FRAME_LEN  (FRAME_LEN),
      .CLK_DIV    (CLK_DIV),
      .IDLE_LEVEL (IDLE_LEVEL)
   ) u_shifter (
      .clk_in       (clk_in),
      .reset_in     (reset_in),
      .load_in      (load),
      .frame_in     (frame_sel),
      .done_out     (shift_end),
      .ser_clk_out  (ser_clk_out),
      .ser_data_out (ser_data_out)
   );

   assign gnt_out  = gnt_q;
   assign done_out = done_q;
   assign busy_out = (state_q != IDLE);

`ifdef ETHER_CMD_SCHED_STATS_EN
   logic [15:0] frame_cnt_q, frame_cnt_d;

   always_comb begin
      frame_cnt_d = frame_cnt_q;
      if ((done_d != '0) && (frame_cnt_q != 16'hFFFF)) begin
         frame_cnt_d = frame_cnt_q + 16'd1;
      end
   end

   always_ff @(posedge clk_in) begin
      if (!reset_in) begin
         frame_cnt_q <= '0;
      end else begin
         frame_cnt_q <= frame_cnt_d;
      end
   end

   assign frame_cnt_out = frame_cnt_q;
`endif

endmodule

// File: tb/tb_ether_cmd_sched.sv
// Scoreboard bench for ether_cmd_sched: stimulus queues expected grants, bits and dones; a negedge monitor checks them.
module tb_ether_cmd_sched;
   import ether_cmd_pkg::*;

   localparam int NREQ      = 3;
   localparam int FL        = 58;
   localparam int CD        = 4;
   localparam int GB        = 16;
   localparam int FRAME_CYC = FL * 2 * CD;
   localparam int GAP_CYC   = GB * 2 * CD;

   logic                 clk_in   = 1'b0;
   logic                 reset_in = 1'b0;
   logic [NREQ-1:0]      req_in   = '0;
   logic [NREQ*FL-1:0]   frame_in = '0;
   logic [NREQ-1:0]      gnt_out;
   logic [NREQ-1:0]      done_out;
   logic                 busy_out;
   logic                 ser_clk_out;
   logic                 ser_data_out;
`ifdef ETHER_CMD_SCHED_STATS_EN
   logic [15:0]          frame_cnt_out;
   int                   exp_cnt = 0;
`endif

   ether_cmd_sched #(
      .NREQ       (NREQ),
      .FRAME_LEN  (FL),
      .CLK_DIV    (CD),
      .GAP_BITS   (GB),
      .IDLE_LEVEL (1'b1)
   ) dut (
      .clk_in       (clk_in),
      .reset_in     (reset_in),
      .req_in       (req_in),
      .frame_in     (frame_in),
      .gnt_out      (gnt_out),
      .done_out     (done_out),
      .busy_out     (busy_out),
      .ser_clk_out  (ser_clk_out),
      .ser_data_out (ser_data_out)
`ifdef ETHER_CMD_SCHED_STATS_EN
      ,
      .frame_cnt_out (frame_cnt_out)
`endif
   );

   always #5 clk_in = ~clk_in;

   typedef struct {
      logic [NREQ-1:0] gnt;
      int              gap;
   } gnt_exp_t;

   gnt_exp_t        exp_gnt_q[$];
   logic [NREQ-1:0] exp_done_q[$];
   logic            exp_bit_q[$];

   int       n_checks = 0;
   int       n_fail   = 0;
   int       cyc      = 0;
   int       n_gnt    = 0;
   int       n_done   = 0;
   int       last_gnt_cyc  = 0;
   int       last_done_cyc = 0;
   int       bit_idx  = 0;
   logic     prev_clk = 1'b1;
   gnt_exp_t mon_e;
   logic [NREQ-1:0] mon_d;
   logic     mon_b;

   always @(posedge clk_in) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: consumes expectations whenever the DUT presents a grant, done or serial bit.
   always @(negedge clk_in) begin
      if (!reset_in) begin
         prev_clk = 1'b1;
         bit_idx  = 0;
`ifdef ETHER_CMD_SCHED_STATS_EN
         exp_cnt  = 0;
`endif
      end else begin
         if (gnt_out != '0) begin
            n_gnt++;
            if (exp_gnt_q.size() == 0) begin
               check("unexpected_gnt", 64'(gnt_out), 64'd0);
            end else begin
               mon_e = exp_gnt_q.pop_front();
               check("gnt_value", 64'(gnt_out), 64'(mon_e.gnt));
               if (mon_e.gap >= 0) check("gnt_gap_after_done", 64'(cyc - last_done_cyc), 64'(mon_e.gap));
            end
            last_gnt_cyc = cyc;
            bit_idx      = 0;
         end
         if (done_out != '0) begin
            n_done++;
            if (exp_done_q.size() == 0) begin
               check("unexpected_done", 64'(done_out), 64'd0);
            end else begin
               mon_d = exp_done_q.pop_front();
               check("done_value", 64'(done_out), 64'(mon_d));
               check("done_latency", 64'(cyc - last_gnt_cyc), 64'(FRAME_CYC));
            end
            last_done_cyc = cyc;
`ifdef ETHER_CMD_SCHED_STATS_EN
            exp_cnt++;
            check("frame_cnt_at_done", 64'(frame_cnt_out), 64'(exp_cnt));
`endif
         end
         if (busy_out && ser_clk_out && !prev_clk) begin
            if (exp_bit_q.size() == 0) begin
               check("unexpected_bit", 64'd1, 64'd0);
            end else begin
               mon_b = exp_bit_q.pop_front();
               check($sformatf("ser_bit%0d", bit_idx), 64'(ser_data_out), 64'(mon_b));
            end
            bit_idx++;
         end
         prev_clk = ser_clk_out;
      end
   end

   task automatic set_frame(input int idx, input logic [FL-1:0] f);
      frame_in[idx*FL +: FL] = f;
   endtask

   task automatic push_gnt(input logic [NREQ-1:0] g, input int gap);
      gnt_exp_t e;
      e.gnt = g;
      e.gap = gap;
      exp_gnt_q.push_back(e);
   endtask

   task automatic push_bits(input logic [FL-1:0] f, input int nbits);
      for (int b = FL - 1; b >= FL - nbits; b--) exp_bit_q.push_back(f[b]);
   endtask

   task automatic push_frame(input logic [NREQ-1:0] g, input int gap, input logic [FL-1:0] f);
      push_gnt(g, gap);
      push_bits(f, FL);
      exp_done_q.push_back(g);
   endtask

   // sel 0 waits on grants seen, sel 1 on dones seen; an expired budget is a failure.
   task automatic wait_count(input string name, input int sel, input int target, input int budget);
      int k;
      k = 0;
      while ((((sel == 0) ? n_gnt : n_done) < target) && (k < budget)) begin
         @(negedge clk_in);
         #1;
         k++;
      end
      if (((sel == 0) ? n_gnt : n_done) < target) begin
         n_checks++;
         n_fail++;
         $display("FAIL timeout_%s: seen %0d, wanted %0d", name, (sel == 0) ? n_gnt : n_done, target);
      end
   endtask

   task automatic do_reset();
      reset_in = 1'b0;
      req_in   = '0;
      repeat (3) @(posedge clk_in);
      #1;
      reset_in = 1'b1;
   endtask

   initial begin
      int order[4];
      order = '{0, 1, 2, 0};

      // Reset state
      repeat (3) @(posedge clk_in);
      #1;
      check("reset_gnt", 64'(gnt_out), 64'd0);
      check("reset_done", 64'(done_out), 64'd0);
      check("reset_busy", 64'(busy_out), 64'd0);
      check("reset_ser_clk", 64'(ser_clk_out), 64'd1);
      check("reset_ser_data", 64'(ser_data_out), 64'd1);
`ifdef ETHER_CMD_SCHED_STATS_EN
      check("reset_frame_cnt", 64'(frame_cnt_out), 64'd0);
`endif
      reset_in = 1'b1;
      set_frame(0, CMD_SEND_OUT);
      set_frame(1, CMD_PHY_OFF);
      set_frame(2, CMD_PHY_ON);

      // Single request, then gap boundary
      push_frame(3'b010, -1, CMD_PHY_OFF);
      req_in = 3'b010;
      wait_count("t1_gnt", 0, n_gnt + 1, 10);
      req_in = '0;
      wait_count("t1_done", 1, n_done + 1, FRAME_CYC + 20);
      repeat (GAP_CYC - 2) @(posedge clk_in);
      #1;
      check("t1_busy_last_gap_cycle", 64'(busy_out), 64'd1);
      @(posedge clk_in);
      #1;
      check("t1_busy_after_gap", 64'(busy_out), 64'd0);

      // Round-robin 0,1,2,0 with re-raise after own done
      do_reset();
      push_frame(3'b001, -1, CMD_SEND_OUT);
      push_frame(3'b010, GAP_CYC, CMD_PHY_OFF);
      push_frame(3'b100, GAP_CYC, CMD_PHY_ON);
      push_frame(3'b001, GAP_CYC, CMD_SEND_OUT);
      req_in = 3'b111;
      for (int f = 0; f < 4; f++) begin
         wait_count("t2_gnt", 0, n_gnt + 1, GAP_CYC + 20);
         if (f == 3) req_in = '0;
         else req_in[order[f]] = 1'b0;
         wait_count("t2_done", 1, n_done + 1, FRAME_CYC + 20);
         if (f < 3) req_in[order[f]] = 1'b1;
      end

      // Late request during SHIFT is only served after the full gap
      do_reset();
      push_frame(3'b001, -1, CMD_SEND_OUT);
      push_frame(3'b100, GAP_CYC, CMD_PHY_ON);
      req_in = 3'b001;
      wait_count("t3_gnt0", 0, n_gnt + 1, 10);
      req_in = '0;
      repeat (200) @(posedge clk_in);
      #1;
      req_in[2] = 1'b1;
      wait_count("t3_gnt2", 0, n_gnt + 1, FRAME_CYC + GAP_CYC + 20);
      req_in = '0;
      wait_count("t3_done", 1, n_done + 1, FRAME_CYC + 20);

      // Reset during bit 20 abandons the frame and clears the pointer
      do_reset();
      push_gnt(3'b001, -1);
      push_bits(CMD_SEND_OUT, 20);
      req_in = 3'b001;
      wait_count("t4_gnt", 0, n_gnt + 1, 10);
      req_in = '0;
      repeat (20 * 2 * CD + 1) @(posedge clk_in);
      #1;
      reset_in = 1'b0;
      @(posedge clk_in);
      #1;
      check("t4_ser_clk", 64'(ser_clk_out), 64'd1);
      check("t4_ser_data", 64'(ser_data_out), 64'd1);
      check("t4_busy", 64'(busy_out), 64'd0);
      check("t4_no_done", 64'(done_out), 64'd0);
      check("t4_bits_before_reset", 64'(exp_bit_q.size()), 64'd0);
      repeat (2) @(posedge clk_in);
      #1;
      reset_in = 1'b1;
      push_frame(3'b010, -1, CMD_PHY_OFF);
      req_in = 3'b110;
      wait_count("t4_gnt1", 0, n_gnt + 1, 10);
      req_in = '0;
      wait_count("t4_done1", 1, n_done + 1, FRAME_CYC + 20);

      // frame_in changed after grant must not alter the frame in flight
      do_reset();
      push_frame(3'b100, -1, CMD_PHY_ON);
      req_in = 3'b100;
      wait_count("t5_gnt", 0, n_gnt + 1, 10);
      req_in = '0;
      @(posedge clk_in);
      #1;
      set_frame(2, ~CMD_PHY_ON);
      wait_count("t5_done", 1, n_done + 1, FRAME_CYC + 20);
      set_frame(2, CMD_PHY_ON);

      repeat (10) @(posedge clk_in);
      #1;
      check("left_gnt_expect", 64'(exp_gnt_q.size()), 64'd0);
      check("left_done_expect", 64'(exp_done_q.size()), 64'd0);
      check("left_bit_expect", 64'(exp_bit_q.size()), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
